// File: rtl/asg_burst_ch_if.sv
// Config, table-write and output bundle for one ASG burst channel.
// The register block drives the master side; the channel core is the slave side.
interface asg_burst_ch_if #(
  parameter int DW  = 14,
  parameter int AW  = 14,
  parameter int FW  = 16,
  parameter int CW  = 16,
  parameter int DLW = 32
) ();
  logic              tbl_we_i;
  logic [AW-1:0]     tbl_waddr_i;
  logic [DW-1:0]     tbl_wdata_i;
  logic [1:0]        trig_src_i;
  logic              trig_sw_i;
  logic              trig_ext_i;
  logic [AW+FW-1:0]  size_i;
  logic [AW+FW-1:0]  step_i;
  logic [AW+FW-1:0]  ofs_i;
  logic              wrap_i;
  logic [DW-1:0]     amp_i;
  logic [DW-1:0]     dc_i;
  logic [CW-1:0]     ncyc_i;
  logic [CW-1:0]     nrep_i;
  logic [DLW-1:0]    rdly_i;
  logic [DW-1:0]     dac_o;
  logic              busy_o;
  logic              trig_o;

  modport master (
    output tbl_we_i, tbl_waddr_i, tbl_wdata_i, trig_src_i, trig_sw_i, trig_ext_i,
    output size_i, step_i, ofs_i, wrap_i, amp_i, dc_i, ncyc_i, nrep_i, rdly_i,
    input  dac_o, busy_o, trig_o
  );

  modport slave (
    input  tbl_we_i, tbl_waddr_i, tbl_wdata_i, trig_src_i, trig_sw_i, trig_ext_i,
    input  size_i, step_i, ofs_i, wrap_i, amp_i, dc_i, ncyc_i, nrep_i, rdly_i,
    output dac_o, busy_o, trig_o
  );
endinterface

// File: rtl/asg_burst_ch.sv
// Single-channel arbitrary signal generator: table RAM, burst/repetition FSM, 3-stage scaling pipeline.
// Optional macro ASG_HOLD_LAST_EN: outside RUN after a completed burst, hold the last sample instead of zero.
module asg_burst_ch #(
  parameter int DW  = 14,
  parameter int AW  = 14,
  parameter int FW  = 16,
  parameter int CW  = 16,
  parameter int DLW = 32
) (
  input logic           dac_clk_i,
  input logic           dac_rst_i,
  asg_burst_ch_if.slave bus
);
  localparam int PW  = AW + FW;
  localparam int PRW = 2*DW + 1;
  localparam int SW  = 2*DW + 2;
  localparam logic [PW:0] ONE_PERIOD = {{AW{1'b0}}, 1'b1, {FW{1'b0}}};
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DELAY} state_t;

  state_t          state_reg, state_next;
  logic [PW-1:0]   phase_reg, phase_next;
  logic [CW-1:0]   cyc_reg, cyc_next;
  logic [CW-1:0]   rep_reg, rep_next;
  logic [DLW-1:0]  dly_reg, dly_next;
  logic            trig_out;

  logic [DW-1:0]   mem [0:(1<<AW)-1];
  logic [DW-1:0]   ram_q_reg;
  logic            ext_reg, ext_prev_reg;
  logic            trig;

  logic [PW:0]     nxt;
  logic [PW-1:0]   wrap_val;
  logic [CW-1:0]   cyc_inc;
  logic            period_end, burst_end;

  logic            run_d1_reg;
  logic signed [DW-1:0]  sample;
  logic signed [PRW-1:0] prod_reg, prod_next;
  logic signed [SW-1:0]  sum;
  logic signed [DW-1:0]  dac_reg, dac_next;

  // Read-first RAM: a same-address write and read in one clock return the old word.
  always_ff @(posedge dac_clk_i) begin
    if (bus.tbl_we_i)
      mem[bus.tbl_waddr_i] <= bus.tbl_wdata_i;
  end

  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i)
      ram_q_reg <= '0;
    else
      ram_q_reg <= mem[phase_reg[PW-1:FW]];
  end

  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      ext_reg      <= 1'b0;
      ext_prev_reg <= 1'b0;
    end else begin
      ext_reg      <= bus.trig_ext_i;
      ext_prev_reg <= ext_reg;
    end
  end

  always_comb begin
    trig = 1'b0;
    case (bus.trig_src_i)
      2'd1:    trig = bus.trig_sw_i;
      2'd2:    trig = ext_reg & ~ext_prev_reg;
      2'd3:    trig = ~ext_reg & ext_prev_reg;
      default: trig = 1'b0;
    endcase
  end

  // Phase arithmetic is one bit wider so the overflow past size_i is visible.
  assign nxt        = {1'b0, phase_reg} + {1'b0, bus.step_i};
  assign wrap_val   = PW'(nxt - {1'b0, bus.size_i} - ONE_PERIOD);
  assign period_end = nxt > {1'b0, bus.size_i};
  assign cyc_inc    = cyc_reg + 1'b1;
  assign burst_end  = period_end && (bus.ncyc_i != '0) && (cyc_inc == bus.ncyc_i);

  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      state_reg <= ST_IDLE;
      phase_reg <= '0;
      cyc_reg   <= '0;
      rep_reg   <= '0;
      dly_reg   <= '0;
    end else begin
      state_reg <= state_next;
      phase_reg <= phase_next;
      cyc_reg   <= cyc_next;
      rep_reg   <= rep_next;
      dly_reg   <= dly_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    cyc_next   = cyc_reg;
    rep_next   = rep_reg;
    dly_next   = dly_reg;
    trig_out   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (trig) begin
          state_next = ST_RUN;
          phase_next = bus.ofs_i;
          cyc_next   = '0;
          rep_next   = CW'(1);
          trig_out   = 1'b1;
        end
      end
      ST_RUN: begin
        if (period_end) begin
          cyc_next   = cyc_inc;
          phase_next = bus.wrap_i ? wrap_val : '0;
        end else begin
          phase_next = nxt[PW-1:0];
        end
        if (burst_end) begin
          if ((bus.nrep_i != '0) && (rep_reg == bus.nrep_i)) begin
            state_next = ST_IDLE;
          end else begin
            state_next = ST_DELAY;
            dly_next   = bus.rdly_i;
          end
        end
      end
      ST_DELAY: begin
        // A load of 0 or 1 both restart after a single DELAY clock.
        if (dly_reg < DLW'(2)) begin
          state_next = ST_RUN;
          phase_next = bus.ofs_i;
          cyc_next   = '0;
          rep_next   = rep_reg + 1'b1;
          trig_out   = 1'b1;
        end else begin
          dly_next = dly_reg - 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (bus.trig_src_i == 2'd0) begin
      state_next = ST_IDLE;
      trig_out   = 1'b0;
    end
  end

`ifdef ASG_HOLD_LAST_EN
  logic          hold_reg, hold_d1_reg;
  logic [DW-1:0] last_reg;

  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      hold_reg    <= 1'b0;
      hold_d1_reg <= 1'b0;
      last_reg    <= '0;
    end else begin
      if (bus.trig_src_i == 2'd0)
        hold_reg <= 1'b0;
      else if ((state_reg == ST_RUN) && burst_end)
        hold_reg <= 1'b1;
      else if ((state_reg == ST_IDLE) && trig)
        hold_reg <= 1'b0;
      hold_d1_reg <= hold_reg;
      if (run_d1_reg)
        last_reg <= ram_q_reg;
    end
  end

  assign sample = run_d1_reg ? $signed(ram_q_reg) : (hold_d1_reg ? $signed(last_reg) : '0);
`else
  assign sample = run_d1_reg ? $signed(ram_q_reg) : '0;
`endif

  assign prod_next = PRW'(sample) * PRW'($signed({1'b0, bus.amp_i}));
  assign sum       = SW'(prod_reg >>> (DW-1)) + SW'($signed(bus.dc_i));

  always_comb begin
    dac_next = sum[DW-1:0];
    if (sum > SAT_MAX)
      dac_next = SAT_MAX[DW-1:0];
    else if (sum < SAT_MIN)
      dac_next = SAT_MIN[DW-1:0];
  end

  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      run_d1_reg <= 1'b0;
      prod_reg   <= '0;
      dac_reg    <= '0;
    end else begin
      run_d1_reg <= (state_reg == ST_RUN);
      prod_reg   <= prod_next;
      dac_reg    <= dac_next;
    end
  end

  assign bus.dac_o  = dac_reg;
  assign bus.busy_o = (state_reg != ST_IDLE);
  assign bus.trig_o = trig_out;
endmodule

// File: tb/tb_asg_burst_ch.sv
// Directed bench for asg_burst_ch with DW=14, AW=4, FW=16; outputs sampled on the falling edge.
module tb_asg_burst_ch;
  localparam int DW  = 14;
  localparam int AW  = 4;
  localparam int FW  = 16;
  localparam int CW  = 16;
  localparam int DLW = 32;
  localparam int PW  = AW + FW;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  asg_burst_ch_if #(.DW(DW), .AW(AW), .FW(FW), .CW(CW), .DLW(DLW)) bus ();

  asg_burst_ch #(.DW(DW), .AW(AW), .FW(FW), .CW(CW), .DLW(DLW)) dut (
    .dac_clk_i (clk),
    .dac_rst_i (rst),
    .bus       (bus)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) begin
      $display("chk %s obs=%0d exp=%0d", tag, obs, exp);
    end else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] pv(input int v);
    return PW'(v);
  endfunction

  function automatic logic [DW-1:0] dv(input int v);
    return DW'(v);
  endfunction

  task automatic wr(input int a, input int d);
    bus.tbl_we_i    = 1'b1;
    bus.tbl_waddr_i = AW'(a);
    bus.tbl_wdata_i = dv(d);
    tick();
    bus.tbl_we_i    = 1'b0;
  endtask

  // Software trigger; returns in the cycle holding the first burst sample on dac_o.
  task automatic start(input string tag);
    bus.trig_sw_i = 1'b1;
    #1;
    chk({tag, "_trig"}, bus.trig_o, 1);
    tick();
    bus.trig_sw_i = 1'b0;
    chk({tag, "_busy"}, bus.busy_o, 1);
    tick();
    tick();
    tick();
  endtask

  task automatic stop();
    bus.trig_src_i = 2'd0;
    tick();
    bus.trig_src_i = 2'd1;
  endtask

  // Burst schedule relative to the first trig_o pulse: RUN windows start at 1, 27, 53.
  function automatic int burst_dac(input int c);
    int k;
    int r;
    k = c - 3;
    for (int b = 0; b < 3; b++) begin
      r = 1 + 26*b;
      if (k >= r && k < r + 16)
        return 1000*((k - r) % 8) + 50;
    end
    return 50;
  endfunction

  int wrap1_seq[9] = '{0, 3, 6, 1, 4, 7, 2, 5, 0};
  int wrap0_seq[6] = '{0, 3, 6, 0, 3, 6};
  int half_seq[8]  = '{0, 0, 1, 1, 2, 2, 3, 3};

  initial begin
    rst             = 1'b1;
    bus.tbl_we_i    = 1'b0;
    bus.tbl_waddr_i = '0;
    bus.tbl_wdata_i = '0;
    bus.trig_src_i  = 2'd0;
    bus.trig_sw_i   = 1'b0;
    bus.trig_ext_i  = 1'b0;
    bus.size_i      = pv(7 << 16);
    bus.step_i      = pv(1 << 16);
    bus.ofs_i       = '0;
    bus.wrap_i      = 1'b1;
    bus.amp_i       = dv(14'h2000);
    bus.dc_i        = '0;
    bus.ncyc_i      = '0;
    bus.nrep_i      = '0;
    bus.rdly_i      = '0;
    tick(); tick(); tick();
    chk("rst_dac", $signed(bus.dac_o), 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_trig", bus.trig_o, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) wr(i, 1000*i);
    bus.trig_src_i = 2'd1;
    tick();
    chk("idle_busy", bus.busy_o, 0);

    // Continuous playback
    start("cont");
    for (int i = 0; i < 12; i++) begin
      chk("cont_dac", $signed(bus.dac_o), 1000*(i % 8));
      tick();
    end

    // Reset mid-RUN, then retrigger to prove the table survived
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rstrun_busy", bus.busy_o, 0);
      chk("rstrun_dac", $signed(bus.dac_o), 0);
    end
    rst = 1'b0;
    tick();
    chk("rstrel_dac", $signed(bus.dac_o), 0);
    start("retrig");
    for (int i = 0; i < 4; i++) begin
      chk("retrig_dac", $signed(bus.dac_o), 1000*i);
      tick();
    end
    stop();

    // Wrap with fractional carry, wrap to zero, half-rate step
    bus.step_i = pv(3 << 16);
    bus.wrap_i = 1'b1;
    start("wrap1");
    for (int i = 0; i < 9; i++) begin
      chk("wrap1_dac", $signed(bus.dac_o), 1000*wrap1_seq[i]);
      tick();
    end
    stop();
    bus.wrap_i = 1'b0;
    start("wrap0");
    for (int i = 0; i < 6; i++) begin
      chk("wrap0_dac", $signed(bus.dac_o), 1000*wrap0_seq[i]);
      tick();
    end
    stop();
    bus.wrap_i = 1'b1;
    bus.step_i = pv(32'h8000);
    start("half");
    for (int i = 0; i < 8; i++) begin
      chk("half_dac", $signed(bus.dac_o), 1000*half_seq[i]);
      tick();
    end
    stop();

    // Saturation and fractional gain
    wr(8, 8000);
    wr(9, -8000);
    wr(10, 4000);
    bus.size_i = pv(15 << 16);
    bus.step_i = '0;
    bus.ofs_i  = pv(8 << 16);
    bus.amp_i  = dv(14'h3FFF);
    bus.dc_i   = dv(8000);
    start("satp");
    chk("satp_dac", $signed(bus.dac_o), 8191);
    tick();
    chk("satp_dac2", $signed(bus.dac_o), 8191);
    stop();
    bus.ofs_i = pv(9 << 16);
    bus.dc_i  = dv(-8000);
    start("satn");
    chk("satn_dac", $signed(bus.dac_o), -8192);
    stop();
    bus.ofs_i = pv(10 << 16);
    bus.amp_i = dv(14'h1000);
    bus.dc_i  = '0;
    start("half_gain");
    chk("gain_dac", $signed(bus.dac_o), 2000);
    stop();

    // Burst: 2 periods x 3 repetitions, 10 idle clocks, external rising edge
    bus.size_i     = pv(7 << 16);
    bus.step_i     = pv(1 << 16);
    bus.ofs_i      = '0;
    bus.amp_i      = dv(14'h2000);
    bus.dc_i       = dv(50);
    bus.ncyc_i     = CW'(2);
    bus.nrep_i     = CW'(3);
    bus.rdly_i     = DLW'(10);
    bus.trig_src_i = 2'd2;
    tick(); tick(); tick(); tick();
    chk("burst_pre_dac", $signed(bus.dac_o), 50);
    bus.trig_ext_i = 1'b1;
    tick();
    chk("burst_trig0", bus.trig_o, 1);
    for (int c = 1; c < 76; c++) begin
      tick();
      chk("burst_trig", bus.trig_o, (c == 26 || c == 52) ? 1 : 0);
      chk("burst_busy", bus.busy_o, (c >= 1 && c <= 68) ? 1 : 0);
      chk("burst_dac", $signed(bus.dac_o), burst_dac(c));
      if (c == 5) bus.trig_ext_i = 1'b0;
      if (c == 8) bus.trig_ext_i = 1'b1;
    end

    // Stop mid-RUN with a same-address table write in the same clock
    bus.trig_src_i = 2'd0;
    tick();
    bus.trig_src_i = 2'd1;
    bus.ncyc_i     = '0;
    bus.nrep_i     = '0;
    bus.step_i     = '0;
    bus.ofs_i      = pv(5 << 16);
    bus.dc_i       = dv(100);
    tick(); tick(); tick();
    start("stop");
    chk("stop_run_dac", $signed(bus.dac_o), 5100);
    bus.trig_src_i  = 2'd0;
    bus.tbl_we_i    = 1'b1;
    bus.tbl_waddr_i = AW'(5);
    bus.tbl_wdata_i = dv(1234);
    tick();
    bus.tbl_we_i = 1'b0;
    chk("stop_busy", bus.busy_o, 0);
    chk("stop_dac1", $signed(bus.dac_o), 5100);
    tick();
    chk("stop_dac2", $signed(bus.dac_o), 5100);
    tick();
    chk("stop_old_data", $signed(bus.dac_o), 5100);
    tick();
    chk("stop_dc", $signed(bus.dac_o), 100);
    bus.trig_src_i = 2'd1;
    start("newdata");
    chk("newdata_dac", $signed(bus.dac_o), 1334);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
